// File: rtl/des_pkg.sv
// des_pkg: shared DES constants for the iterative round engine.
// Holds the IP/FP/E/P index tables (1-based, bit 1 = MSB), S1..S8, FSM encoding and mode values.
// No ports; imported by des_f and des_round_engine.
package des_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic DES_ENC = 1'b0;
    localparam logic DES_DEC = 1'b1;

    localparam logic [4:0] LAST_ROUND = 5'd16;

    localparam int IP_TBL [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7
    };

    localparam int FP_TBL [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25
    };

    localparam int E_TBL [48] = '{
        32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1
    };

    localparam int P_TBL [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25
    };

    // Each S-box is 64 nibbles, row-major (row 0 col 0 in the top nibble).
    localparam logic [255:0] SBOX_TBL [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    // Outer bits of the 6-bit group pick the row, inner four pick the column.
    function automatic logic [3:0] sbox_lookup(input int n, input logic [5:0] x);
        int idx;
        idx = 16 * int'({x[5], x[0]}) + int'(x[4:1]);
        return SBOX_TBL[n][255 - 4*idx -: 4];
    endfunction

endpackage

// File: rtl/des_f.sv
// des_f: DES round function f(R, K) = P(S(E(R) ^ K)), purely combinational.
// Ports: R[32] right half (bit 1 = MSB), K[48] round subkey, F[32] result.
// Zero latency; no flow control.
module des_f
    import des_pkg::*;
(
    input  logic [31:0] R,
    input  logic [47:0] K,
    output logic [31:0] F
);

    logic [47:0] w_x;
    logic [31:0] w_s;

    // DES bit n of a W-bit vector lives at index W-n.
    always_comb begin
        w_x = '0;
        for (int i = 0; i < 48; i++) begin
            w_x[47 - i] = R[32 - E_TBL[i]];
        end
        w_x = w_x ^ K;
    end

    always_comb begin
        w_s = '0;
        for (int n = 0; n < 8; n++) begin
            w_s[31 - 4*n -: 4] = sbox_lookup(n, w_x[47 - 6*n -: 6]);
        end
    end

    always_comb begin
        F = '0;
        for (int i = 0; i < 32; i++) begin
            F[31 - i] = w_s[32 - P_TBL[i]];
        end
    end

endmodule

// File: rtl/des_round_engine.sv
// des_round_engine: iterative DES encrypt/decrypt, one Feistel round per cycle, 16 cycles accept->out_valid.
// Ports: in_valid/in_ready/mode/key_in/data_in accept a block; key_out/keyid drive the external
//   subkey generator whose subkey returns in the same cycle; out_valid/out_ready/data_out deliver the result.
// Backpressure: DONE holds data_out/out_valid until out_ready; in_ready is low outside IDLE.
module des_round_engine
    import des_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        mode,
    input  logic [63:0] key_in,
    input  logic [63:0] data_in,
    output logic [63:0] key_out,
    output logic [4:0]  keyid,
    input  logic [47:0] subkey,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] data_out
);

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [31:0] r_l;
    logic [31:0] r_r;
    logic [63:0] r_key;
    logic        r_mode;
    logic [63:0] r_dout;

    logic [63:0] w_ip;
    logic [31:0] w_f;
    logic [31:0] w_r_nxt;
    logic [63:0] w_pre;
    logic [63:0] w_fp;

    always_comb begin
        w_ip = '0;
        for (int i = 0; i < 64; i++) begin
            w_ip[63 - i] = data_in[64 - IP_TBL[i]];
        end
    end

    des_f u_f (
        .R (r_r),
        .K (subkey),
        .F (w_f)
    );

    assign w_r_nxt = r_l ^ w_f;

    // Preimage of FP is {R16, L16}: the round-16 result with no final swap.
    assign w_pre = {w_r_nxt, r_r};

    always_comb begin
        w_fp = '0;
        for (int i = 0; i < 64; i++) begin
            w_fp[63 - i] = w_pre[64 - FP_TBL[i]];
        end
    end

    // Decrypt walks the schedule backwards; outside ROUND the index parks at 1.
    always_comb begin
        keyid = 5'd1;
        if (r_state == ST_ROUND) begin
            keyid = (r_mode == DES_ENC) ? r_cnt : (5'd17 - r_cnt);
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign key_out   = r_key;
    assign data_out  = r_dout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 5'd0;
            r_l     <= '0;
            r_r     <= '0;
            r_key   <= '0;
            r_mode  <= DES_ENC;
            r_dout  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_l     <= w_ip[63:32];
                        r_r     <= w_ip[31:0];
                        r_key   <= key_in;
                        r_mode  <= mode;
                        r_cnt   <= 5'd1;
                        r_state <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    r_l <= r_r;
                    r_r <= w_r_nxt;
                    if (r_cnt == LAST_ROUND) begin
                        r_dout  <= w_fp;
                        r_cnt   <= 5'd0;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_des_round_engine.sv
// tb_des_round_engine: randomized and directed checks of des_round_engine against a behavioural DES model.
// Provides the combinational subkey generator beside the DUT (PC1/shifts/PC2 from key_out and keyid).
// Drives and samples on the falling clock edge; the DUT registers on the rising edge.
module tb_des_round_engine;
    import des_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        mode;
    logic [63:0] key_in;
    logic [63:0] data_in;
    logic [63:0] key_out;
    logic [4:0]  keyid;
    logic [47:0] subkey;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] data_out;

    int n_cmp = 0;
    int n_err = 0;

    int          lat;
    logic [4:0]  trace [16];
    logic [63:0] res;

    localparam logic [63:0] KEY_V = 64'h133457799BBCDFF1;
    localparam logic [63:0] PT_V  = 64'h0123456789ABCDEF;
    localparam logic [63:0] CT_V  = 64'h85E813540F0AB405;
    localparam logic [63:0] ZERO_CT = 64'h8CA64DE9C1B123A7;

    localparam int PC1_TB [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2_TB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SHIFT_TB [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    always #5 clk = ~clk;

    des_round_engine dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .key_in    (key_in),
        .data_in   (data_in),
        .key_out   (key_out),
        .keyid     (keyid),
        .subkey    (subkey),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out)
    );

    // Round-n subkey: total left-rotation of C/D after n rounds, then PC2.
    function automatic logic [47:0] tb_subkey(input logic [63:0] key, input int rnd);
        logic [55:0] cd;
        logic [27:0] c;
        logic [27:0] d;
        logic [47:0] k;
        int sh;
        for (int i = 0; i < 56; i++) cd[55 - i] = key[64 - PC1_TB[i]];
        c  = cd[55:28];
        d  = cd[27:0];
        sh = 0;
        for (int r = 0; r < rnd && r < 16; r++) sh += SHIFT_TB[r];
        sh = sh % 28;
        c  = (c << sh) | (c >> (28 - sh));
        d  = (d << sh) | (d >> (28 - sh));
        cd = {c, d};
        for (int i = 0; i < 48; i++) k[47 - i] = cd[56 - PC2_TB[i]];
        return k;
    endfunction

    assign subkey = tb_subkey(key_out, int'(keyid));

    function automatic logic [31:0] ref_f(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        logic [31:0] p;
        int six, row, col, pos;
        for (int i = 0; i < 48; i++) x[47 - i] = r[32 - E_TBL[i]];
        x = x ^ k;
        for (int n = 0; n < 8; n++) begin
            six = int'(x[47 - 6*n -: 6]);
            row = (six >> 5) * 2 + (six & 1);
            col = (six >> 1) & 15;
            pos = row * 16 + col;
            s[31 - 4*n -: 4] = 4'(SBOX_TBL[n] >> (4 * (63 - pos)));
        end
        for (int i = 0; i < 32; i++) p[31 - i] = s[32 - P_TBL[i]];
        return p;
    endfunction

    // Full DES; the output permutation is computed as the inverse of IP.
    function automatic logic [63:0] ref_des(input logic [63:0] k, input logic [63:0] d, input logic m);
        logic [63:0] ip;
        logic [63:0] pre;
        logic [63:0] o;
        logic [31:0] l, r, t;
        for (int i = 0; i < 64; i++) ip[63 - i] = d[64 - IP_TBL[i]];
        l = ip[63:32];
        r = ip[31:0];
        for (int rd = 1; rd <= 16; rd++) begin
            t = r;
            r = l ^ ref_f(r, tb_subkey(k, m ? 17 - rd : rd));
            l = t;
        end
        pre = {r, l};
        for (int i = 0; i < 64; i++) o[64 - IP_TBL[i]] = pre[63 - i];
        return o;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Called on a falling edge; returns on the falling edge after the accept (round 1 in flight).
    task automatic send(input logic [63:0] k, input logic [63:0] d, input logic m);
        int t;
        t = 0;
        key_in   = k;
        data_in  = d;
        mode     = m;
        in_valid = 1'b1;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("send_timeout", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic collect(input bit disturb);
        lat = 0;
        for (int i = 0; i < 16; i++) trace[i] = 5'd0;
        while (!out_valid && lat < 40) begin
            if (lat < 16) trace[lat] = keyid;
            if (disturb) begin
                mode   = ~mode;
                key_in = {$urandom, $urandom};
            end
            lat++;
            @(negedge clk);
        end
        if (!out_valid) chk("out_valid_timeout", 64'(out_valid), 64'd1);
        res = data_out;
    endtask

    task automatic check_block(input string tag, input logic [63:0] k, input logic [63:0] d, input logic m);
        chk({tag, "_data"}, res, ref_des(k, d, m));
        chk({tag, "_latency"}, 64'(lat), 64'd16);
        chk({tag, "_key_out"}, key_out, k);
        for (int i = 0; i < 16; i++) begin
            chk({tag, "_keyid"}, 64'(trace[i]), 64'(m ? 16 - i : i + 1));
        end
    endtask

    task automatic drain(input int bp);
        out_ready = 1'b0;
        for (int i = 0; i < bp; i++) begin
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_data_stable", data_out, res);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_keyid", 64'(keyid), 64'd1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("post_hs_out_valid", 64'(out_valid), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rk, rd;
        logic        rm;
        bit          seen;

        rst       = 1'b1;
        in_valid  = 1'b0;
        mode      = 1'b0;
        key_in    = '0;
        data_in   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_keyid", 64'(keyid), 64'd1);
        chk("rst_key_out", key_out, 64'd0);
        chk("rst_data_out", data_out, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        send(KEY_V, PT_V, DES_ENC);
        collect(1'b0);
        check_block("enc", KEY_V, PT_V, DES_ENC);
        chk("enc_known", res, CT_V);
        drain(0);

        send(KEY_V, CT_V, DES_DEC);
        collect(1'b0);
        check_block("dec", KEY_V, CT_V, DES_DEC);
        chk("dec_known", res, PT_V);
        drain(0);

        send(64'd0, 64'd0, DES_ENC);
        collect(1'b0);
        check_block("zero", 64'd0, 64'd0, DES_ENC);
        chk("zero_known", res, ZERO_CT);
        drain(0);

        // Backpressure with the next block already offered.
        send(KEY_V, PT_V, DES_ENC);
        collect(1'b0);
        check_block("bp", KEY_V, PT_V, DES_ENC);
        key_in   = 64'd0;
        data_in  = 64'd0;
        mode     = DES_ENC;
        in_valid = 1'b1;
        drain(5);
        chk("bp_idle_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        chk("bp_next_accepted", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        collect(1'b0);
        check_block("bp_next", 64'd0, 64'd0, DES_ENC);
        chk("bp_next_known", res, ZERO_CT);
        drain(0);

        // Reset at round 8.
        send({$urandom, $urandom}, {$urandom, $urandom}, DES_ENC);
        repeat (7) @(negedge clk);
        chk("mid_keyid_pre", 64'(keyid), 64'd8);
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_keyid", 64'(keyid), 64'd1);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("mid_rst_no_valid", 64'(seen), 64'd0);
        send(KEY_V, PT_V, DES_ENC);
        collect(1'b0);
        check_block("after_rst", KEY_V, PT_V, DES_ENC);
        chk("after_rst_known", res, CT_V);
        drain(0);

        // Inputs toggling during ROUND must not disturb the block.
        send(KEY_V, PT_V, DES_ENC);
        collect(1'b1);
        check_block("isolate", KEY_V, PT_V, DES_ENC);
        chk("isolate_known", res, CT_V);
        drain(0);

        for (int it = 0; it < 10; it++) begin
            rk = {$urandom, $urandom};
            rd = {$urandom, $urandom};
            rm = 1'($urandom_range(0, 1));
            send(rk, rd, rm);
            collect(1'b0);
            check_block("rand", rk, rd, rm);
            drain(int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
